// File: rtl/dma_priority_arbiter.sv
// Channel arbiter and CPU bus-hold sequencer for the 4-channel DMA controller.
// Optional software request register is compiled in with `define DMA_SOFT_REQ_EN.
module dma_priority_arbiter #(
  parameter int HOLD_TIMEOUT = 0,
  parameter int TIMEOUT_W    = 8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] DREQ,
  input  logic [3:0] maskedChannels,
  input  logic       rotatingPriority,
  input  logic       HLDA,
  input  logic       xferDone,
`ifdef DMA_SOFT_REQ_EN
  input  logic       softReqWr,
  input  logic [1:0] softReqCh,
  input  logic       softReqSet,
`endif
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic [1:0] activeChannel,
  output logic       busy,
  output logic       holdTimeout
);

  typedef enum logic [1:0] {IDLE, HOLD_REQ, GRANT, RELEASE} state_t;

  localparam bit                   TO_EN   = (HOLD_TIMEOUT > 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TO_EN ? HOLD_TIMEOUT - 1 : 0);

  state_t               state;
  logic [1:0]           top;       // channel currently holding highest priority
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [3:0]           eff_req;
  logic [1:0]           winner;
  logic                 timeout_hit;

`ifdef DMA_SOFT_REQ_EN
  logic [3:0] soft_req;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      soft_req <= '0;
    end else begin
      if (state == GRANT && xferDone)
        soft_req[activeChannel] <= 1'b0;
      // Listed last so a write to the same bit overrides the completion clear.
      if (softReqWr)
        soft_req[softReqCh] <= softReqSet;
    end
  end

  assign eff_req = (DREQ | soft_req) & ~maskedChannels;
`else
  assign eff_req = DREQ & ~maskedChannels;
`endif

  // Scan from lowest priority to highest so the highest-priority hit is kept.
  function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] first);
    logic [1:0] ch;
    // NOTE: give every combinational result a default before any conditional
    // update; a path that leaves it unassigned infers a latch.
    pick_winner = first;
    for (int k = 3; k >= 0; k--) begin
      ch = first + 2'(k);
      if (req[ch]) pick_winner = ch;
    end
  endfunction

  always_comb begin
    winner = pick_winner(eff_req, top);
  end

  assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state         <= IDLE;
      HRQ           <= 1'b0;
      DACK          <= 4'b0000;
      activeChannel <= 2'd0;
      busy          <= 1'b0;
      holdTimeout   <= 1'b0;
      top           <= 2'd0;
      wait_cnt      <= '0;
    end else begin
      holdTimeout <= 1'b0;
      if (!rotatingPriority)
        top <= 2'd0;

      case (state)
        // RELEASE lasts one cycle with the bus dropped, then arbitrates like IDLE.
        IDLE, RELEASE: begin
          if (eff_req != 4'b0000) begin
            state    <= HOLD_REQ;
            HRQ      <= 1'b1;
            wait_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end

        HOLD_REQ: begin
          if (HLDA) begin
            if (eff_req != 4'b0000) begin
              state         <= GRANT;
              DACK          <= 4'b0001 << winner;
              activeChannel <= winner;
              busy          <= 1'b1;
            end else begin
              state <= RELEASE;
              HRQ   <= 1'b0;
            end
          end else if (timeout_hit) begin
            holdTimeout <= 1'b1;
            state       <= RELEASE;
            HRQ         <= 1'b0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        GRANT: begin
          if (xferDone || !HLDA) begin
            state         <= (xferDone && HLDA) ? RELEASE : IDLE;
            HRQ           <= 1'b0;
            DACK          <= 4'b0000;
            activeChannel <= 2'd0;
            busy          <= 1'b0;
            // Only a completed transfer rotates; an aborted one leaves order alone.
            if (xferDone && rotatingPriority)
              top <= activeChannel + 2'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed vector table, corner sequences,
// then randomized traffic against a channel-list reference model.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       reset;
  logic [3:0] DREQ, maskedChannels;
  logic       rotatingPriority, HLDA, xferDone;
  logic       HRQ, busy, holdTimeout;
  logic [3:0] DACK;
  logic [1:0] activeChannel;

  logic [3:0] t_dreq;
  logic       t_hlda;
  logic       t_hrq, t_busy, t_to;
  logic [3:0] t_dack;
  logic [1:0] t_ch;

`ifdef DMA_SOFT_REQ_EN
  logic       softReqWr, softReqSet;
  logic [1:0] softReqCh;
`endif

  int checks = 0;
  int errors = 0;

  dma_priority_arbiter dut (
    .CLK(CLK), .reset(reset), .DREQ(DREQ), .maskedChannels(maskedChannels),
    .rotatingPriority(rotatingPriority), .HLDA(HLDA), .xferDone(xferDone),
`ifdef DMA_SOFT_REQ_EN
    .softReqWr(softReqWr), .softReqCh(softReqCh), .softReqSet(softReqSet),
`endif
    .HRQ(HRQ), .DACK(DACK), .activeChannel(activeChannel), .busy(busy),
    .holdTimeout(holdTimeout)
  );

  dma_priority_arbiter #(.HOLD_TIMEOUT(5)) dut_to (
    .CLK(CLK), .reset(reset), .DREQ(t_dreq), .maskedChannels(4'b0000),
    .rotatingPriority(1'b0), .HLDA(t_hlda), .xferDone(1'b0),
`ifdef DMA_SOFT_REQ_EN
    .softReqWr(1'b0), .softReqCh(2'd0), .softReqSet(1'b0),
`endif
    .HRQ(t_hrq), .DACK(t_dack), .activeChannel(t_ch), .busy(t_busy),
    .holdTimeout(t_to)
  );

  typedef struct {
    logic [3:0] dreq;
    logic [3:0] mask;
    logic       hlda;
    logic       xd;
    logic       hrq;
    logic [3:0] dack;
    logic [1:0] ch;
    logic       busy;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input logic [3:0] dreq, input logic [3:0] mask,
                              input logic hlda, input logic xd, input logic hrq,
                              input logic [3:0] dack, input logic [1:0] ch,
                              input logic bsy);
    vec_t v;
    v.dreq = dreq; v.mask = mask; v.hlda = hlda; v.xd = xd;
    v.hrq = hrq; v.dack = dack; v.ch = ch; v.busy = bsy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy) break;
    end
    check("wait for grant", busy, 1);
  endtask

  // Reference model: a priority list rebuilt from the serviced channel.
  int   m_gnt;
  bit   m_hrq;
  int   m_order[4];

  function automatic int model_pick(input logic [3:0] eff);
    for (int k = 0; k < 4; k++)
      if (eff[m_order[k]]) return m_order[k];
    return -1;
  endfunction

  task automatic model_fixed_order();
    for (int k = 0; k < 4; k++) m_order[k] = k;
  endtask

  task automatic model_step();
    logic [3:0] eff;
    eff = DREQ & ~maskedChannels;
    if (!reset) begin
      m_gnt = -1; m_hrq = 0; model_fixed_order();
    end else begin
      if (m_gnt >= 0) begin
        if (xferDone) begin
          if (rotatingPriority)
            for (int k = 0; k < 4; k++) m_order[k] = (m_gnt + 1 + k) % 4;
          m_gnt = -1; m_hrq = 0;
        end else if (!HLDA) begin
          m_gnt = -1; m_hrq = 0;
        end
      end else if (m_hrq) begin
        if (HLDA) begin
          if (eff != 0) m_gnt = model_pick(eff);
          else m_hrq = 0;
        end
      end else if (eff != 0) begin
        m_hrq = 1;
      end
      if (!rotatingPriority) model_fixed_order();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; DREQ = '0; maskedChannels = '0; rotatingPriority = 1'b0;
    HLDA = 1'b0; xferDone = 1'b0; t_dreq = '0; t_hlda = 1'b0;
`ifdef DMA_SOFT_REQ_EN
    softReqWr = 1'b0; softReqCh = 2'd0; softReqSet = 1'b0;
`endif
    tick(); tick();
    check("reset outputs", {HRQ, DACK, activeChannel, busy, holdTimeout}, 0);
    check("reset outputs to", {t_hrq, t_dack, t_ch, t_busy, t_to}, 0);
    reset = 1'b1;

    // Fixed priority grant, release, re-grant, masking, withdrawn request.
    vt[0]  = mk(4'b0101, 4'b0000, 0, 0, 1, 4'b0000, 0, 0);
    vt[1]  = mk(4'b0101, 4'b0000, 0, 0, 1, 4'b0000, 0, 0);
    vt[2]  = mk(4'b0101, 4'b0000, 0, 0, 1, 4'b0000, 0, 0);
    vt[3]  = mk(4'b0101, 4'b0000, 1, 0, 1, 4'b0001, 0, 1);
    vt[4]  = mk(4'b0100, 4'b0000, 1, 0, 1, 4'b0001, 0, 1);
    vt[5]  = mk(4'b0100, 4'b0000, 1, 1, 0, 4'b0000, 0, 0);
    vt[6]  = mk(4'b0100, 4'b0000, 0, 0, 1, 4'b0000, 0, 0);
    vt[7]  = mk(4'b0100, 4'b0000, 1, 0, 1, 4'b0100, 2, 1);
    vt[8]  = mk(4'b0000, 4'b0000, 1, 1, 0, 4'b0000, 0, 0);
    vt[9]  = mk(4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 0, 0);
    vt[10] = mk(4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 0, 0);
    vt[11] = mk(4'b0010, 4'b0000, 0, 0, 1, 4'b0000, 0, 0);
    vt[12] = mk(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0);
    vt[13] = mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);

    for (int i = 0; i < 14; i++) begin
      DREQ = vt[i].dreq; maskedChannels = vt[i].mask;
      HLDA = vt[i].hlda; xferDone = vt[i].xd;
      tick();
      check($sformatf("vec%0d hrq/dack/busy", i), {HRQ, DACK, busy},
            {vt[i].hrq, vt[i].dack, vt[i].busy});
      if (vt[i].busy)
        check($sformatf("vec%0d channel", i), activeChannel, vt[i].ch);
    end
    HLDA = 1'b0; xferDone = 1'b0;

    // Hold timeout: HRQ for 5 cycles, pulse, one low cycle, re-request.
    t_dreq = 4'b0001;
    tick();
    check("to hrq rise", {t_hrq, t_to}, 2'b10);
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("to waiting %0d", k), {t_hrq, t_to}, 2'b10);
    end
    tick();
    check("to pulse", {t_hrq, t_to}, 2'b01);
    tick();
    check("to re-request", {t_hrq, t_to}, 2'b10);
    t_dreq = 4'b0000;

    // Rotating priority: ch0, ch1, ch2, ch3, ch0, then fixed order returns.
    do_reset();
    rotatingPriority = 1'b1; DREQ = 4'b1111; HLDA = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_busy(10);
      check($sformatf("rotate grant %0d", g), activeChannel, g % 4);
      xferDone = 1'b1;
      tick();
      xferDone = 1'b0;
      check($sformatf("rotate release %0d", g), {HRQ, DACK, busy}, 0);
    end
    rotatingPriority = 1'b0;
    wait_busy(10);
    check("fixed order restored", activeChannel, 0);
    xferDone = 1'b1;
    tick();
    xferDone = 1'b0;

    // Abort on HLDA loss leaves priority untouched; reset mid-grant.
    do_reset();
    rotatingPriority = 1'b1; DREQ = 4'b0100; HLDA = 1'b1;
    wait_busy(10);
    check("abort setup ch2", activeChannel, 2);
    HLDA = 1'b0;
    tick();
    check("abort outputs", {HRQ, DACK, busy}, 0);
    DREQ = 4'b1111; HLDA = 1'b1;
    wait_busy(10);
    check("abort no rotate", activeChannel, 0);
    reset = 1'b0;
    tick();
    check("reset mid-grant", {HRQ, DACK, activeChannel, busy, holdTimeout}, 0);
    reset = 1'b1; DREQ = 4'b0000; HLDA = 1'b0; rotatingPriority = 1'b0;
    tick();

`ifdef DMA_SOFT_REQ_EN
    do_reset();
    HLDA = 1'b1;
    softReqWr = 1'b1; softReqCh = 2'd3; softReqSet = 1'b1;
    tick();
    softReqWr = 1'b0;
    wait_busy(10);
    check("soft grant", DACK, 4'b1000);
    xferDone = 1'b1;
    tick();
    xferDone = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("soft cleared %0d", k), HRQ, 0);
    end
    HLDA = 1'b0;
`endif

    // Randomized traffic against the reference model.
    reset = 1'b0;
    @(posedge CLK);
    model_step();
    #1;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) != 0);
      DREQ = 4'($urandom);
      maskedChannels = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 31) == 0) rotatingPriority = ~rotatingPriority;
      if ($urandom_range(0, 3) == 0) HLDA = ~HLDA;
      xferDone = ($urandom_range(0, 3) == 0);
      @(posedge CLK);
      model_step();
      #1;
      check($sformatf("rand %0d hrq/dack/busy/to", c), {HRQ, DACK, busy, holdTimeout},
            {m_hrq, (m_gnt >= 0) ? 4'(1 << m_gnt) : 4'b0000, m_gnt >= 0, 1'b0});
      if (m_gnt >= 0)
        check($sformatf("rand %0d channel", c), activeChannel, m_gnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
